// File: rtl/seg_frame_decoder.sv
// -----------------------------------------------------------------------------
// seg_frame_decoder
//
// Receive side of the serial 7-segment display link. Deserialises the
// DIGITS-byte segment stream, which is shifted MSB first on seg_sclk rising
// edges and closed by a seg_latch rising edge. Each byte is decoded back into
// a hex nibble, a decimal point, a blank flag and an illegal-pattern flag.
// Segment bytes are {a,b,c,d,e,f,g,p}, active-low (0 = lit).
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_sclk     serial shift clock (async to clk, period >= 4 clk)
//   seg_sdin     serial segment data, sampled on seg_sclk rise
//   seg_latch    frame latch strobe, rising edge ends a frame
//   hex_out      decoded nibbles, digit k = hex_out[4k+3:4k]
//   point_out    1 = decimal point lit
//   blank_out    1 = digit blanked (pattern all ones)
//   illegal_out  1 = non-blank pattern not found in the hex table
//   frame_valid  one-cycle pulse: a good frame was decoded
//   frame_err    one-cycle pulse: latch arrived with the wrong bit count
//   bit_cnt      bits received in the current frame, saturating at 8*DIGITS+1
// -----------------------------------------------------------------------------
module seg_frame_decoder #(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seg_sclk,
    input  logic                  seg_sdin,
    input  logic                  seg_latch,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     point_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [DIGITS-1:0]     illegal_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [6:0]            bit_cnt
);

    localparam int         FRAME_BITS = 8 * DIGITS;
    localparam logic [6:0] CNT_FULL   = 7'(FRAME_BITS);
    // One past a full frame marks overflow; the counter parks there.
    localparam logic [6:0] CNT_OVF    = 7'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers and edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] sdin_sync_reg;
    logic [SYNC_STAGES-1:0] latch_sync_reg;
    logic                   sclk_d_reg;
    logic                   latch_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg  <= '0;
            sdin_sync_reg  <= '0;
            latch_sync_reg <= '0;
            sclk_d_reg     <= 1'b0;
            latch_d_reg    <= 1'b0;
        end else begin
            sclk_sync_reg  <= {sclk_sync_reg[SYNC_STAGES-2:0], seg_sclk};
            sdin_sync_reg  <= {sdin_sync_reg[SYNC_STAGES-2:0], seg_sdin};
            latch_sync_reg <= {latch_sync_reg[SYNC_STAGES-2:0], seg_latch};
            sclk_d_reg     <= sclk_sync_reg[SYNC_STAGES-1];
            latch_d_reg    <= latch_sync_reg[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic sdin_s;
    logic latch_s;
    logic sclk_rise;
    logic latch_rise;

    assign sclk_s     = sclk_sync_reg[SYNC_STAGES-1];
    assign sdin_s     = sdin_sync_reg[SYNC_STAGES-1];
    assign latch_s    = latch_sync_reg[SYNC_STAGES-1];
    // sdin travels through the same number of stages as sclk, so the data
    // seen alongside a detected sclk rise is the value present at that rise.
    assign sclk_rise  = sclk_s  & ~sclk_d_reg;
    assign latch_rise = latch_s & ~latch_d_reg;

    // -------------------------------------------------------------------------
    // Per-digit combinational decode of the current shift register contents
    // -------------------------------------------------------------------------
    logic [FRAME_BITS-1:0] shift_reg;
    logic [4*DIGITS-1:0]   dec_hex;
    logic [DIGITS-1:0]     dec_point;
    logic [DIGITS-1:0]     dec_blank;
    logic [DIGITS-1:0]     dec_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dec
            logic [7:0] seg_byte;
            logic [3:0] hex_d;
            logic       blank_d;
            logic       illegal_d;

            assign seg_byte = shift_reg[8*gi +: 8];

            always_comb begin
                hex_d     = 4'h0;
                blank_d   = 1'b0;
                illegal_d = 1'b0;
                case (seg_byte[7:1])
                    7'b1111111: blank_d = 1'b1;
                    7'b0000001: hex_d   = 4'h0;
                    7'b1001111: hex_d   = 4'h1;
                    7'b0010010: hex_d   = 4'h2;
                    7'b0000110: hex_d   = 4'h3;
                    7'b1001100: hex_d   = 4'h4;
                    7'b0100100: hex_d   = 4'h5;
                    7'b0100000: hex_d   = 4'h6;
                    7'b0001111: hex_d   = 4'h7;
                    7'b0000000: hex_d   = 4'h8;
                    7'b0000100: hex_d   = 4'h9;
                    7'b0001000: hex_d   = 4'hA;
                    7'b1100000: hex_d   = 4'hB;
                    7'b0110001: hex_d   = 4'hC;
                    7'b1000010: hex_d   = 4'hD;
                    7'b0110000: hex_d   = 4'hE;
                    7'b0111000: hex_d   = 4'hF;
                    default:    illegal_d = 1'b1;
                endcase
            end

            assign dec_hex[4*gi +: 4] = hex_d;
            assign dec_point[gi]      = ~seg_byte[0];
            assign dec_blank[gi]      = blank_d;
            assign dec_illegal[gi]    = illegal_d;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Frame FSM, shift register, bit counter and registered outputs
    // -------------------------------------------------------------------------
    state_t                state_reg;
    logic [6:0]            bit_cnt_reg;
    logic [4*DIGITS-1:0]   hex_reg;
    logic [DIGITS-1:0]     point_reg;
    logic [DIGITS-1:0]     blank_reg;
    logic [DIGITS-1:0]     illegal_reg;
    logic                  valid_reg;
    logic                  err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            hex_reg     <= '0;
            point_reg   <= '0;
            blank_reg   <= '0;
            illegal_reg <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_SHIFT: begin
                    // A shift coinciding with the latch is taken first, so
                    // that bit counts toward the frame being closed.
                    if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], sdin_s};
                        if (bit_cnt_reg != CNT_OVF) begin
                            bit_cnt_reg <= bit_cnt_reg + 7'd1;
                        end
                    end
                    if (latch_rise) begin
                        state_reg <= ST_CHECK;
                    end else if (sclk_rise) begin
                        state_reg <= ST_SHIFT;
                    end
                end

                ST_CHECK: begin
                    if (bit_cnt_reg == CNT_FULL) begin
                        hex_reg     <= dec_hex;
                        point_reg   <= dec_point;
                        blank_reg   <= dec_blank;
                        illegal_reg <= dec_illegal;
                        valid_reg   <= 1'b1;
                    end else begin
                        err_reg <= 1'b1;
                    end
                    // A rise arriving now opens the next frame after the clear.
                    if (sclk_rise) begin
                        shift_reg   <= {{(FRAME_BITS-1){1'b0}}, sdin_s};
                        bit_cnt_reg <= 7'd1;
                    end else begin
                        shift_reg   <= '0;
                        bit_cnt_reg <= '0;
                    end
                    state_reg <= ST_IDLE;
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign hex_out     = hex_reg;
    assign point_out   = point_reg;
    assign blank_out   = blank_reg;
    assign illegal_out = illegal_reg;
    assign frame_valid = valid_reg;
    assign frame_err   = err_reg;
    assign bit_cnt     = bit_cnt_reg;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_frame_decoder
//
// Directed bench for seg_frame_decoder (DIGITS=8, SYNC_STAGES=2). Frames are
// hand-encoded 64-bit words, digit 7 byte first, shifted MSB first.
// -----------------------------------------------------------------------------
module tb_seg_frame_decoder;

    logic        clk;
    logic        rst_n;
    logic        seg_sclk;
    logic        seg_sdin;
    logic        seg_latch;
    logic [31:0] hex_out;
    logic [7:0]  point_out;
    logic [7:0]  blank_out;
    logic [7:0]  illegal_out;
    logic        frame_valid;
    logic        frame_err;
    logic [6:0]  bit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // digits 7..0 = 1,2,3,4,5,6,7,8, points off
    localparam logic [63:0] FRAME_A = 64'h9F25_0D99_4941_1F01;
    // digit7 blank, 6..1 = E,d,C,b,A,9, digit0 = '0' with point lit
    localparam logic [63:0] FRAME_B = 64'hFF61_8563_C111_0902;
    // FRAME_A with digit 3 replaced by 8'h55 (not in the table)
    localparam logic [63:0] FRAME_C = 64'h9F25_0D99_5541_1F01;

    seg_frame_decoder #(
        .DIGITS      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_sclk    (seg_sclk),
        .seg_sdin    (seg_sdin),
        .seg_latch   (seg_latch),
        .hex_out     (hex_out),
        .point_out   (point_out),
        .blank_out   (blank_out),
        .illegal_out (illegal_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .bit_cnt     (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] hex, input logic [7:0] pnt,
                               input logic [7:0] blk, input logic [7:0] ill);
        check_eq({tag, ".hex"},     64'(hex_out),     64'(hex));
        check_eq({tag, ".point"},   64'(point_out),   64'(pnt));
        check_eq({tag, ".blank"},   64'(blank_out),   64'(blk));
        check_eq({tag, ".illegal"}, 64'(illegal_out), 64'(ill));
    endtask

    // One serial bit: data with sclk low for 3 clk, then sclk high for 3 clk.
    task automatic send_bit(input logic b);
        @(negedge clk);
        seg_sdin = b;
        seg_sclk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        seg_sclk = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_bits(input logic [63:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(data[i]);
        end
    endtask

    // Raise the latch (optionally releasing reset or raising sclk in the same
    // cycle) and check the pulse timing: nothing at edge 2, pulse at edge 3,
    // gone at edge 4. bit_cnt is checked while the FSM sits in CHECK.
    task automatic latch_and_check(input string tag, input logic release_rst, input logic with_sclk,
                                   input logic exp_valid, input logic exp_err, input logic [6:0] exp_cnt);
        @(negedge clk);
        seg_latch = 1'b1;
        if (release_rst) rst_n = 1'b1;
        if (with_sclk)   seg_sclk = 1'b1;
        @(posedge clk);                 // edge 0
        @(posedge clk);                 // edge 1
        @(posedge clk);                 // edge 2
        #1;
        check_eq({tag, ".valid@2"}, 64'(frame_valid), 64'd0);
        check_eq({tag, ".err@2"},   64'(frame_err),   64'd0);
        check_eq({tag, ".cnt@2"},   64'(bit_cnt),     64'(exp_cnt));
        @(posedge clk);                 // edge 3
        #1;
        check_eq({tag, ".valid@3"}, 64'(frame_valid), 64'(exp_valid));
        check_eq({tag, ".err@3"},   64'(frame_err),   64'(exp_err));
        check_eq({tag, ".cnt@3"},   64'(bit_cnt),     64'd0);
        @(posedge clk);                 // edge 4
        #1;
        check_eq({tag, ".valid@4"}, 64'(frame_valid), 64'd0);
        check_eq({tag, ".err@4"},   64'(frame_err),   64'd0);
        @(negedge clk);
        seg_latch = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_sclk  = 1'b0;
        seg_sdin  = 1'b0;
        seg_latch = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_frame("reset", 32'h0, 8'h00, 8'h00, 8'h00);
        check_eq("reset.valid", 64'(frame_valid), 64'd0);
        check_eq("reset.err",   64'(frame_err),   64'd0);
        check_eq("reset.cnt",   64'(bit_cnt),     64'd0);

        // Latch already high at release: empty frame -> error, outputs stay 0.
        latch_and_check("empty", 1'b1, 1'b0, 1'b0, 1'b1, 7'd0);
        check_frame("empty", 32'h0, 8'h00, 8'h00, 8'h00);

        send_bits(FRAME_A, 64);
        latch_and_check("frameA", 1'b0, 1'b0, 1'b1, 1'b0, 7'd64);
        check_frame("frameA", 32'h1234_5678, 8'h00, 8'h00, 8'h00);

        send_bits(FRAME_B, 64);
        latch_and_check("frameB", 1'b0, 1'b0, 1'b1, 1'b0, 7'd64);
        check_frame("frameB", 32'h0EDC_BA90, 8'h01, 8'h80, 8'h00);

        send_bits(FRAME_C, 64);
        latch_and_check("frameC", 1'b0, 1'b0, 1'b1, 1'b0, 7'd64);
        check_frame("frameC", 32'h1234_0678, 8'h00, 8'h00, 8'h08);

        // Short frame: error, last good frame held.
        send_bits(FRAME_B >> 1, 63);
        latch_and_check("short63", 1'b0, 1'b0, 1'b0, 1'b1, 7'd63);
        check_frame("short63", 32'h1234_0678, 8'h00, 8'h00, 8'h08);

        // Long frame: counter saturates at 65, error, last good frame held.
        send_bits(FRAME_B, 64);
        send_bits(64'h2A, 6);
        latch_and_check("long70", 1'b0, 1'b0, 1'b0, 1'b1, 7'd65);
        check_frame("long70", 32'h1234_0678, 8'h00, 8'h00, 8'h08);

        // Reset mid-frame clears everything immediately.
        send_bits(FRAME_A >> 34, 30);
        @(negedge clk);
        rst_n    = 1'b0;
        seg_sclk = 1'b0;
        #1;
        check_frame("midrst", 32'h0, 8'h00, 8'h00, 8'h00);
        check_eq("midrst.cnt", 64'(bit_cnt), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        send_bits(FRAME_B, 64);
        latch_and_check("afterrst", 1'b0, 1'b0, 1'b1, 1'b0, 7'd64);
        check_frame("afterrst", 32'h0EDC_BA90, 8'h01, 8'h80, 8'h00);

        // Last sclk rise coincides with the latch rise: still a 64-bit frame.
        send_bits(FRAME_A >> 1, 63);
        @(negedge clk);
        seg_sdin = FRAME_A[0];
        seg_sclk = 1'b0;
        repeat (3) @(posedge clk);
        latch_and_check("coincide", 1'b0, 1'b1, 1'b1, 1'b0, 7'd64);
        check_frame("coincide", 32'h1234_5678, 8'h00, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
